mmio_register_responder: RTL

//  AFU-side responder for PSL MMIO requests. Host-initiated reads/writes are decoded against the AFU MMIO map.

---
 rtl/mmio_register_responder_pkg.sv | 106 ++++++++++
 rtl/mmio_register_responder_parity.sv | 23 ++
 rtl/mmio_register_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_register_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmio_register_responder_pkg
//   Shared types and constants for the AFU-side PSL MMIO responder.
//   - CAPI request/response bundles (MMIOInterfaceInput / MMIOInterfaceOutput)
//   - responder FSM state encoding (mmio_state_t)
//   - AFU MMIO register word addresses and ERROR_REG bit positions
//   - small decode helpers shared by the responder logic
//
// Bit numbering: the PSL documents its buses big-endian ([0:63], bit 0 is the
// MSB). Inside the RTL every vector is declared [N-1:0], so PSL bit n lives at
// index (N-1-n). psl_bit() performs that conversion for the error positions.
// -----------------------------------------------------------------------------
package mmio_register_responder_pkg;

    localparam int unsigned ADDR_W = 24;   // ha_mmad width (word address)
    localparam int unsigned DATA_W = 64;   // ha_mmdata / ah_mmdata width

    // Captured host request.
    typedef struct packed {
        logic              valid;
        logic              cfg;
        logic              rnw;
        logic              dw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              datapar;
    } MMIOInterfaceInput;

    // Response driven back to the PSL.
    typedef struct packed {
        logic              ack;
        logic [DATA_W-1:0] data;
        logic              datapar;
    } MMIOInterfaceOutput;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACK    = 2'd2
    } mmio_state_t;

    // Result of the address decode.
    typedef enum logic [2:0] {
        SEL_NONE         = 3'd0,
        SEL_ALGO_STATUS  = 3'd1,
        SEL_ALGO_REQUEST = 3'd2,
        SEL_ERROR_REG    = 3'd3,
        SEL_AFU_STATUS   = 3'd4,
        SEL_ALGO_RUNNING = 3'd5
    } reg_sel_t;

    // Doubleword-aligned word addresses of the AFU registers.
    localparam logic [ADDR_W-1:0] ADDR_ALGO_STATUS  = 24'h00_0000;
    localparam logic [ADDR_W-1:0] ADDR_ALGO_REQUEST = 24'h00_0002;
    localparam logic [ADDR_W-1:0] ADDR_ERROR_REG    = 24'h00_0004;
    localparam logic [ADDR_W-1:0] ADDR_AFU_STATUS   = 24'h00_0006;
    localparam logic [ADDR_W-1:0] ADDR_ALGO_RUNNING = 24'h00_0008;

    // ERROR_REG bit positions in PSL (big-endian) numbering.
    localparam int unsigned ERR_BIT_PROTOCOL = 62;
    localparam int unsigned ERR_BIT_PARITY   = 63;

    // PSL big-endian bit number -> little-endian vector index.
    function automatic int unsigned psl_bit(input int unsigned n);
        return DATA_W - 1 - n;
    endfunction

    localparam logic [DATA_W-1:0] ERR_MASK_PROTOCOL = DATA_W'(1) << psl_bit(ERR_BIT_PROTOCOL);
    localparam logic [DATA_W-1:0] ERR_MASK_PARITY   = DATA_W'(1) << psl_bit(ERR_BIT_PARITY);

    // Address decode. A doubleword access with the low word-address bit set
    // (PSL ad[23]) is misaligned and decodes to nothing.
    function automatic reg_sel_t decode_reg(input logic [ADDR_W-1:0] addr, input logic dw);
        reg_sel_t          sel;
        logic [ADDR_W-1:0] dw_addr;
        sel     = SEL_NONE;
        dw_addr = {addr[ADDR_W-1:1], 1'b0};
        if (!(dw && addr[0])) begin
            case (dw_addr)
                ADDR_ALGO_STATUS:  sel = SEL_ALGO_STATUS;
                ADDR_ALGO_REQUEST: sel = SEL_ALGO_REQUEST;
                ADDR_ERROR_REG:    sel = SEL_ERROR_REG;
                ADDR_AFU_STATUS:   sel = SEL_AFU_STATUS;
                ADDR_ALGO_RUNNING: sel = SEL_ALGO_RUNNING;
                default:           sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Bits touched by a write: all of them for a doubleword, otherwise the
    // addressed 32-bit half. lo_half (PSL ad[23]=1) selects PSL bits [32:63],
    // which are the numerically low bits of the vector.
    function automatic logic [DATA_W-1:0] half_mask(input logic dw, input logic lo_half);
        logic [DATA_W-1:0] mask;
        if (dw) begin
            mask = '1;
        end else if (lo_half) begin
            mask = {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};
        end else begin
            mask = {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mmio_register_responder_parity.sv
// -----------------------------------------------------------------------------
// mmio_parity
//   Odd-parity helper for the PSL MMIO data buses.
//   Ports:
//     check_data / check_par  in   word and parity bit to verify
//     check_ok                out  1 when data plus parity has an odd number of 1s
//     gen_data                in   word to protect
//     gen_par                 out  parity bit making gen_data odd parity
// -----------------------------------------------------------------------------
module mmio_parity #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] check_data,
    input  logic             check_par,
    output logic             check_ok,
    input  logic [WIDTH-1:0] gen_data,
    output logic             gen_par
);

    assign check_ok = ^{check_data, check_par};
    assign gen_par  = ~^gen_data;

endmodule

// File: rtl/mmio_register_responder.sv
// -----------------------------------------------------------------------------
// mmio_register_responder
//   AFU-side responder for PSL MMIO requests. One request is in flight at a
//   time: the request is captured in cycle T, decoded in T+1 (read sources
//   sampled here) and acknowledged in T+2. Every request is acked.
//
//   Ports:
//     clock, rstn          AFU clock, asynchronous active-low reset
//     ha_mm*               PSL MMIO request (valid pulse, cfg, rnw, dw,
//                          word address, write data, odd data parity)
//     ah_mmack/data/par    response; data and parity are only non-zero in
//                          the ack cycle
//     algo_status_in,
//     afu_status_in,
//     algo_running_in      read-only register sources
//     error_in             error set bits, OR-ed into ERROR_REG every cycle
//     algo_request_out     held ALGO_REQUEST value (write-only to the host)
//     algo_request_valid   one-cycle pulse with the ack of an accepted
//                          ALGO_REQUEST write
//
//   PSL bit n maps to vector index (63-n): PSL ad[23] is ha_mmad[0], PSL data
//   bits [0:31] are [63:32]; ERROR_REG bit 63 is index 0, bit 62 is index 1.
// -----------------------------------------------------------------------------
module mmio_register_responder
    import mmio_register_responder_pkg::*;
#(
    parameter int MMIO_ADDR_WIDTH = 24,
    parameter int MMIO_DATA_WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       rstn,

    input  logic                       ha_mmval,
    input  logic                       ha_mmcfg,
    input  logic                       ha_mmrnw,
    input  logic                       ha_mmdw,
    input  logic [MMIO_ADDR_WIDTH-1:0] ha_mmad,
    input  logic [MMIO_DATA_WIDTH-1:0] ha_mmdata,
    input  logic                       ha_mmdatapar,

    output logic                       ah_mmack,
    output logic [MMIO_DATA_WIDTH-1:0] ah_mmdata,
    output logic                       ah_mmdatapar,

    input  logic [MMIO_DATA_WIDTH-1:0] algo_status_in,
    input  logic [MMIO_DATA_WIDTH-1:0] afu_status_in,
    input  logic [MMIO_DATA_WIDTH-1:0] algo_running_in,
    input  logic [MMIO_DATA_WIDTH-1:0] error_in,

    output logic [MMIO_DATA_WIDTH-1:0] algo_request_out,
    output logic                       algo_request_valid
);

    mmio_state_t        state;
    mmio_state_t        state_next;
    MMIOInterfaceInput  req_q;
    MMIOInterfaceOutput rsp_q;

    logic [DATA_W-1:0]   algo_request_q;
    logic                algo_request_valid_q;
    logic [DATA_W-1:0]   error_q;

    reg_sel_t            sel;
    logic                in_decode;
    logic                is_write;
    logic                wr_par_ok;
    logic                wr_accept;
    logic                algo_wr;
    logic                par_err;
    logic                proto_err;
    logic [DATA_W-1:0]   wr_mask;
    logic [DATA_W-1:0]   err_clr;
    logic [DATA_W-1:0]   err_set;
    logic [DATA_W-1:0]   rd_full;
    logic [DATA_W/2-1:0] rd_half;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_par;

    // ---------------------------------------------------------------- FSM
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ha_mmval) state_next = DECODE;
            DECODE:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ request capture
    // Only a request arriving in IDLE is captured; one arriving later is a
    // protocol violation and never disturbs the transaction in flight.
    // NOTE: the captured request is reset as well even though the FSM gates
    // its use, so an asynchronous reset leaves no stale valid behind.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            req_q <= '0;
        end else if (state == IDLE && ha_mmval) begin
            req_q <= '{valid:   1'b1,
                       cfg:     ha_mmcfg,
                       rnw:     ha_mmrnw,
                       dw:      ha_mmdw,
                       addr:    ha_mmad,
                       data:    ha_mmdata,
                       datapar: ha_mmdatapar};
        end else if (state == ACK) begin
            req_q.valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------- parity
    mmio_parity #(.WIDTH(DATA_W)) u_parity (
        .check_data (req_q.data),
        .check_par  (req_q.datapar),
        .check_ok   (wr_par_ok),
        .gen_data   (rsp_data),
        .gen_par    (rsp_par)
    );

    // -------------------------------------------------------------- decode
    always_comb begin
        sel       = decode_reg(req_q.addr, req_q.dw);
        in_decode = (state == DECODE) && req_q.valid;
        is_write  = !req_q.rnw;
        wr_mask   = half_mask(req_q.dw, req_q.addr[0]);

        // Config-space writes and writes with bad parity change nothing.
        wr_accept = in_decode && is_write && wr_par_ok && !req_q.cfg;
        algo_wr   = wr_accept && (sel == SEL_ALGO_REQUEST);
        err_clr   = (wr_accept && (sel == SEL_ERROR_REG)) ? (req_q.data & wr_mask) : '0;

        par_err   = in_decode && is_write && !wr_par_ok;
        proto_err = ha_mmval && (state != IDLE);
        err_set   = error_in
                  | (par_err   ? ERR_MASK_PARITY   : '0)
                  | (proto_err ? ERR_MASK_PROTOCOL : '0);

        // ALGO_REQUEST is write-only and reads back as zero like any
        // unmapped address.
        rd_full = '0;
        case (sel)
            SEL_ALGO_STATUS:  rd_full = algo_status_in;
            SEL_ERROR_REG:    rd_full = error_q;
            SEL_AFU_STATUS:   rd_full = afu_status_in;
            SEL_ALGO_RUNNING: rd_full = algo_running_in;
            default:          rd_full = '0;
        endcase
        if (req_q.cfg) begin
            rd_full = '0;
        end

        // Word reads return the addressed half on both lanes.
        rd_half  = req_q.addr[0] ? rd_full[DATA_W/2-1:0] : rd_full[DATA_W-1:DATA_W/2];
        rsp_data = '0;
        if (req_q.rnw) begin
            rsp_data = req_q.dw ? rd_full : {rd_half, rd_half};
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            error_q              <= '0;
            algo_request_q       <= '0;
            algo_request_valid_q <= 1'b0;
            rsp_q                <= '0;
        end else begin
            // Clear first, then set, so a same-cycle set wins.
            error_q              <= (error_q & ~err_clr) | err_set;
            algo_request_valid_q <= algo_wr;
            if (algo_wr) begin
                algo_request_q <= (algo_request_q & ~wr_mask) | (req_q.data & wr_mask);
            end
            // Response is presented in the ACK cycle and zero otherwise;
            // a write acks with data 0, whose odd parity is 1.
            rsp_q.ack     <= in_decode;
            rsp_q.data    <= in_decode ? rsp_data : '0;
            rsp_q.datapar <= in_decode && rsp_par;
        end
    end

    assign ah_mmack           = rsp_q.ack;
    assign ah_mmdata          = rsp_q.data;
    assign ah_mmdatapar       = rsp_q.datapar;
    assign algo_request_out   = algo_request_q;
    assign algo_request_valid = algo_request_valid_q;

endmodule
